uvmt_cv32e40x_pma_obi_tracker: RTL and testbench



---
 rtl/uvmt_cv32e40x_pma_obi_tracker.sv | 167 ++++++++++++++++
 tb/tb_uvmt_cv32e40x_pma_obi_tracker.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uvmt_cv32e40x_pma_obi_tracker.sv
// Per-port OBI transaction tracker that checks each granted request against the PMA verdict and retires entries in response order.
// Optional build macro UVMT_PMA_TRACKER_ASSERT_EN adds concurrent assertions and covers; flag outputs and their timing are unchanged.
module uvmt_cv32e40x_pma_obi_tracker #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          IS_INSTR_SIDE   = 1'b0,
  parameter int unsigned RESP_TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        obi_req_i,
  input  logic        obi_gnt_i,
  input  logic [31:0] obi_addr_i,
  input  logic        obi_we_i,
  input  logic [1:0]  obi_memtype_i,
  input  logic        obi_rvalid_i,
  input  logic        obi_err_i,
  input  logic        pma_allow_i,
  input  logic        pma_bufferable_i,
  input  logic        pma_cacheable_i,
  output logic [3:0]  outstanding_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_addr_o,
  output logic        resp_err_o,
  output logic        err_disallowed_o,
  output logic        err_memtype_o,
  output logic        err_overflow_o,
  output logic        err_underflow_o,
  output logic        err_timeout_o,
  output logic        violation_sticky_o
);

  localparam int unsigned     PTR_W     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned     TMO_W     = $clog2(RESP_TIMEOUT + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [3:0]      CNT_MAX   = 4'(MAX_OUTSTANDING);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(RESP_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(RESP_TIMEOUT - 1);

  // Handshakes: an address phase is accepted when obi_req_i && obi_gnt_i in the same
  // cycle; a response is consumed whenever obi_rvalid_i is high (no back-pressure).
  logic        push, pop, empty, full, pop_ok, push_ok, memtype_bad, tmo_expire;
  logic [31:0] addr_mem_q [MAX_OUTSTANDING];
  logic        we_mem_q   [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]       count_q, count_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic        resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [31:0] resp_addr_q, resp_addr_d;
  logic        disallowed_q, disallowed_d, memtype_q, memtype_d;
  logic        overflow_q, overflow_d, underflow_q, underflow_d;
  logic        timeout_q, timeout_d, sticky_q, sticky_d;
  logic        unused_head_we;

  assign unused_head_we = we_mem_q[rd_ptr_q];

  always_comb begin
    push        = obi_req_i && obi_gnt_i;
    pop         = obi_rvalid_i;
    empty       = (count_q == 4'd0);
    full        = (count_q == CNT_MAX);
    pop_ok      = pop && !empty;
    // A same-cycle pop frees the slot the push needs, so push while full is legal then.
    push_ok     = push && (!full || pop_ok);
    memtype_bad = (obi_memtype_i != {pma_cacheable_i, pma_bufferable_i}) ||
                  (IS_INSTR_SIDE && (obi_we_i || obi_memtype_i[0]));
    tmo_expire  = !pop && !empty && (tmo_q == TMO_LAST);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;

    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase

    // Counter measures how long the current head has waited; saturation blocks re-firing.
    tmo_d = tmo_q;
    if (pop || empty)            tmo_d = '0;
    else if (tmo_q != TMO_LIMIT) tmo_d = tmo_q + 1'b1;

    resp_valid_d = pop_ok;
    resp_addr_d  = pop_ok ? addr_mem_q[rd_ptr_q] : 32'h0;
    resp_err_d   = pop_ok && obi_err_i;
    disallowed_d = push && !pma_allow_i;
    memtype_d    = push && memtype_bad;
    overflow_d   = push && full && !pop;
    underflow_d  = pop && empty;
    timeout_d    = tmo_expire;
    sticky_d     = sticky_q || disallowed_d || memtype_d || overflow_d ||
                   underflow_d || timeout_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        addr_mem_q[i] <= 32'h0;
        we_mem_q[i]   <= 1'b0;
      end
    end else if (push_ok) begin
      addr_mem_q[wr_ptr_q] <= obi_addr_i;
      we_mem_q[wr_ptr_q]   <= obi_we_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= 4'd0;
      tmo_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_addr_q  <= 32'h0;
      resp_err_q   <= 1'b0;
      disallowed_q <= 1'b0;
      memtype_q    <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      timeout_q    <= 1'b0;
      sticky_q     <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      tmo_q        <= tmo_d;
      resp_valid_q <= resp_valid_d;
      resp_addr_q  <= resp_addr_d;
      resp_err_q   <= resp_err_d;
      disallowed_q <= disallowed_d;
      memtype_q    <= memtype_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      timeout_q    <= timeout_d;
      sticky_q     <= sticky_d;
    end
  end

  assign outstanding_o      = count_q;
  assign resp_valid_o       = resp_valid_q;
  assign resp_addr_o        = resp_addr_q;
  assign resp_err_o         = resp_err_q;
  assign err_disallowed_o   = disallowed_q;
  assign err_memtype_o      = memtype_q;
  assign err_overflow_o     = overflow_q;
  assign err_underflow_o    = underflow_q;
  assign err_timeout_o      = timeout_q;
  assign violation_sticky_o = sticky_q;

`ifdef UVMT_PMA_TRACKER_ASSERT_EN
  a_disallowed: assert property (@(posedge clk) disable iff (!rst_n) push |-> pma_allow_i)
    else $error("pma tracker: disallowed access reached bus, addr=%08h", obi_addr_i);
  a_memtype: assert property (@(posedge clk) disable iff (!rst_n) push |-> !memtype_bad)
    else $error("pma tracker: memtype mismatch, addr=%08h", obi_addr_i);
  a_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop))
    else $error("pma tracker: overflow, dropped addr=%08h", obi_addr_i);
  a_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty))
    else $error("pma tracker: underflow, response with no entry, addr=%08h", obi_addr_i);
  a_timeout: assert property (@(posedge clk) disable iff (!rst_n) !tmo_expire)
    else $error("pma tracker: response timeout, head addr=%08h", addr_mem_q[rd_ptr_q]);
  c_push_pop_full: cover property (@(posedge clk) disable iff (!rst_n) push && pop && full);
  c_timeout: cover property (@(posedge clk) disable iff (!rst_n) tmo_expire);
`endif

endmodule

// File: tb/tb_uvmt_cv32e40x_pma_obi_tracker.sv
// Directed bench: data-side and instruction-side trackers (depth 2, timeout 4) fed from shared OBI/PMA stimulus.
module tb_uvmt_cv32e40x_pma_obi_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        obi_req_i, obi_gnt_i, obi_we_i, obi_rvalid_i, obi_err_i;
  logic [31:0] obi_addr_i;
  logic [1:0]  obi_memtype_i;
  logic        pma_allow_i, pma_bufferable_i, pma_cacheable_i;

  logic [3:0]  outstanding_o, i_outstanding_o;
  logic [31:0] resp_addr_o, i_resp_addr_o;
  logic        resp_valid_o, resp_err_o, err_disallowed_o, err_memtype_o;
  logic        err_overflow_o, err_underflow_o, err_timeout_o, violation_sticky_o;
  logic        i_resp_valid_o, i_resp_err_o, i_err_disallowed_o, i_err_memtype_o;
  logic        i_err_overflow_o, i_err_underflow_o, i_err_timeout_o, i_violation_sticky_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uvmt_cv32e40x_pma_obi_tracker #(.MAX_OUTSTANDING(2), .IS_INSTR_SIDE(1'b0), .RESP_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .obi_req_i(obi_req_i), .obi_gnt_i(obi_gnt_i),
    .obi_addr_i(obi_addr_i), .obi_we_i(obi_we_i), .obi_memtype_i(obi_memtype_i),
    .obi_rvalid_i(obi_rvalid_i), .obi_err_i(obi_err_i), .pma_allow_i(pma_allow_i),
    .pma_bufferable_i(pma_bufferable_i), .pma_cacheable_i(pma_cacheable_i),
    .outstanding_o(outstanding_o), .resp_valid_o(resp_valid_o), .resp_addr_o(resp_addr_o),
    .resp_err_o(resp_err_o), .err_disallowed_o(err_disallowed_o), .err_memtype_o(err_memtype_o),
    .err_overflow_o(err_overflow_o), .err_underflow_o(err_underflow_o),
    .err_timeout_o(err_timeout_o), .violation_sticky_o(violation_sticky_o));

  uvmt_cv32e40x_pma_obi_tracker #(.MAX_OUTSTANDING(2), .IS_INSTR_SIDE(1'b1), .RESP_TIMEOUT(4)) dut_i (
    .clk(clk), .rst_n(rst_n), .obi_req_i(obi_req_i), .obi_gnt_i(obi_gnt_i),
    .obi_addr_i(obi_addr_i), .obi_we_i(obi_we_i), .obi_memtype_i(obi_memtype_i),
    .obi_rvalid_i(obi_rvalid_i), .obi_err_i(obi_err_i), .pma_allow_i(pma_allow_i),
    .pma_bufferable_i(pma_bufferable_i), .pma_cacheable_i(pma_cacheable_i),
    .outstanding_o(i_outstanding_o), .resp_valid_o(i_resp_valid_o), .resp_addr_o(i_resp_addr_o),
    .resp_err_o(i_resp_err_o), .err_disallowed_o(i_err_disallowed_o), .err_memtype_o(i_err_memtype_o),
    .err_overflow_o(i_err_overflow_o), .err_underflow_o(i_err_underflow_o),
    .err_timeout_o(i_err_timeout_o), .violation_sticky_o(i_violation_sticky_o));

  task automatic drive(input logic push, input logic [31:0] addr, input logic we,
                       input logic [1:0] mt, input logic rv, input logic er,
                       input logic allow, input logic [1:0] pma_mt);
    obi_req_i        = push;
    obi_gnt_i        = push;
    obi_addr_i       = addr;
    obi_we_i         = we;
    obi_memtype_i    = mt;
    obi_rvalid_i     = rv;
    obi_err_i        = er;
    pma_allow_i      = allow;
    pma_cacheable_i  = pma_mt[1];
    pma_bufferable_i = pma_mt[0];
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    step();
    n_cmp++;
    if ({outstanding_o, resp_valid_o, resp_addr_o, resp_err_o} !== 38'h0) begin
      n_fail++;
      $display("FAIL reset_resp: got cnt=%0d rv=%b addr=%08h err=%b want all 0",
               outstanding_o, resp_valid_o, resp_addr_o, resp_err_o);
    end
    n_cmp++;
    if ({err_disallowed_o, err_memtype_o, err_overflow_o, err_underflow_o, err_timeout_o,
         violation_sticky_o} !== 6'h0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b%b%b%b%b%b want 000000", err_disallowed_o, err_memtype_o,
               err_overflow_o, err_underflow_o, err_timeout_o, violation_sticky_o);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    apply_reset();
    drive(1'b1, 32'h0000_1000, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 2'b10);
    obi_gnt_i = 1'b0;
    step();
    n_cmp++;
    if (outstanding_o !== 4'd0) begin
      n_fail++; $display("FAIL req_no_gnt: got cnt=%0d want 0", outstanding_o);
    end
    obi_gnt_i = 1'b1;
    step();
    idle();
    n_cmp++;
    if (outstanding_o !== 4'd1) begin
      n_fail++; $display("FAIL read_push_cnt: got %0d want 1", outstanding_o);
    end
    n_cmp++;
    if ({err_disallowed_o, err_memtype_o, i_err_memtype_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL read_push_flags: got dis=%b mt=%b imt=%b want 000",
               err_disallowed_o, err_memtype_o, i_err_memtype_o);
    end
    step();
    step();
    drive(1'b0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00);
    step();
    idle();
    n_cmp++;
    if ({resp_valid_o, resp_addr_o, resp_err_o, outstanding_o} !== {1'b1, 32'h0000_1000, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL read_resp: got rv=%b addr=%08h err=%b cnt=%0d want 1 00001000 0 0",
               resp_valid_o, resp_addr_o, resp_err_o, outstanding_o);
    end
    n_cmp++;
    if ({err_timeout_o, err_underflow_o, violation_sticky_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL read_clean: got tmo=%b und=%b sticky=%b want 000",
               err_timeout_o, err_underflow_o, violation_sticky_o);
    end
    step();
    n_cmp++;
    if (resp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL resp_pulse: got rv=%b want 0", resp_valid_o);
    end
  endtask

  task automatic test_disallowed();
    apply_reset();
    drive(1'b1, 32'h8000_0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    step();
    idle();
    n_cmp++;
    if ({err_disallowed_o, outstanding_o, violation_sticky_o} !== {1'b1, 4'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL disallowed: got dis=%b cnt=%0d sticky=%b want 1 1 1",
               err_disallowed_o, outstanding_o, violation_sticky_o);
    end
    step();
    n_cmp++;
    if ({err_disallowed_o, violation_sticky_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL disallowed_pulse: got dis=%b sticky=%b want 0 1", err_disallowed_o, violation_sticky_o);
    end
    drive(1'b0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00);
    step();
    idle();
    n_cmp++;
    if ({resp_valid_o, resp_addr_o, outstanding_o, violation_sticky_o} !== {1'b1, 32'h8000_0000, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL disallowed_resp: got rv=%b addr=%08h cnt=%0d sticky=%b want 1 80000000 0 1",
               resp_valid_o, resp_addr_o, outstanding_o, violation_sticky_o);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (violation_sticky_o !== 1'b0) begin
      n_fail++; $display("FAIL sticky_reset: got %b want 0", violation_sticky_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_overflow();
    apply_reset();
    drive(1'b1, 32'h0000_0100, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00);
    step();
    obi_addr_i = 32'h0000_0104;
    step();
    obi_addr_i = 32'h0000_0108;
    n_cmp++;
    if ({outstanding_o, err_overflow_o} !== {4'd2, 1'b0}) begin
      n_fail++; $display("FAIL fill: got cnt=%0d ovf=%b want 2 0", outstanding_o, err_overflow_o);
    end
    step();
    idle();
    n_cmp++;
    if ({outstanding_o, err_overflow_o} !== {4'd2, 1'b1}) begin
      n_fail++; $display("FAIL overflow: got cnt=%0d ovf=%b want 2 1", outstanding_o, err_overflow_o);
    end
    step();
    drive(1'b1, 32'h0000_010C, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00);
    step();
    drive(1'b0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00);
    n_cmp++;
    if ({err_overflow_o, outstanding_o, resp_valid_o, resp_addr_o} !== {1'b0, 4'd2, 1'b1, 32'h0000_0100}) begin
      n_fail++;
      $display("FAIL push_pop_full: got ovf=%b cnt=%0d rv=%b addr=%08h want 0 2 1 00000100",
               err_overflow_o, outstanding_o, resp_valid_o, resp_addr_o);
    end
    step();
    n_cmp++;
    if (resp_addr_o !== 32'h0000_0104) begin
      n_fail++; $display("FAIL order_2nd: got %08h want 00000104", resp_addr_o);
    end
    step();
    idle();
    n_cmp++;
    if ({resp_addr_o, outstanding_o} !== {32'h0000_010C, 4'd0}) begin
      n_fail++;
      $display("FAIL order_3rd: got addr=%08h cnt=%0d want 0000010c 0", resp_addr_o, outstanding_o);
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    drive(1'b0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00);
    step();
    n_cmp++;
    if ({err_underflow_o, resp_valid_o, outstanding_o} !== {1'b1, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL underflow: got und=%b rv=%b cnt=%0d want 1 0 0",
               err_underflow_o, resp_valid_o, outstanding_o);
    end
    drive(1'b1, 32'h0000_0200, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00);
    step();
    drive(1'b0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00);
    n_cmp++;
    if ({err_underflow_o, resp_valid_o, outstanding_o} !== {1'b1, 1'b0, 4'd1}) begin
      n_fail++;
      $display("FAIL underflow_push: got und=%b rv=%b cnt=%0d want 1 0 1",
               err_underflow_o, resp_valid_o, outstanding_o);
    end
    step();
    idle();
    n_cmp++;
    if ({err_underflow_o, resp_valid_o, resp_addr_o} !== {1'b0, 1'b1, 32'h0000_0200}) begin
      n_fail++;
      $display("FAIL underflow_kept: got und=%b rv=%b addr=%08h want 0 1 00000200",
               err_underflow_o, resp_valid_o, resp_addr_o);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    drive(1'b1, 32'h0000_0300, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00);
    step();
    idle();
    for (int i = 1; i <= 6; i++) begin
      step();
      n_cmp++;
      if (err_timeout_o !== (i == 4)) begin
        n_fail++;
        $display("FAIL timeout_cyc%0d: got %b want %b", i, err_timeout_o, (i == 4));
      end
    end
    drive(1'b0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00);
    step();
    idle();
    n_cmp++;
    if ({resp_valid_o, resp_addr_o, outstanding_o, err_timeout_o} !== {1'b1, 32'h0000_0300, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_resp: got rv=%b addr=%08h cnt=%0d tmo=%b want 1 00000300 0 0",
               resp_valid_o, resp_addr_o, outstanding_o, err_timeout_o);
    end
  endtask

  task automatic test_memtype();
    apply_reset();
    drive(1'b1, 32'h0000_0400, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 2'b01);
    step();
    n_cmp++;
    if ({err_memtype_o, i_err_memtype_o} !== 2'b01) begin
      n_fail++; $display("FAIL memtype_write: got d=%b i=%b want 0 1", err_memtype_o, i_err_memtype_o);
    end
    drive(1'b1, 32'h0000_0404, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 2'b01);
    step();
    n_cmp++;
    if ({err_memtype_o, i_err_memtype_o, resp_err_o, resp_addr_o} !== {2'b01, 1'b1, 32'h0000_0400}) begin
      n_fail++;
      $display("FAIL memtype_buf: got d=%b i=%b rerr=%b addr=%08h want 0 1 1 00000400",
               err_memtype_o, i_err_memtype_o, resp_err_o, resp_addr_o);
    end
    drive(1'b1, 32'h0000_0408, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 2'b10);
    step();
    n_cmp++;
    if ({err_memtype_o, i_err_memtype_o, resp_err_o} !== 3'b110) begin
      n_fail++;
      $display("FAIL memtype_mismatch: got d=%b i=%b rerr=%b want 1 1 0",
               err_memtype_o, i_err_memtype_o, resp_err_o);
    end
    drive(1'b0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00);
    step();
    idle();
    n_cmp++;
    if ({outstanding_o, err_memtype_o, resp_addr_o} !== {4'd0, 1'b0, 32'h0000_0408}) begin
      n_fail++;
      $display("FAIL memtype_drain: got cnt=%0d mt=%b addr=%08h want 0 0 00000408",
               outstanding_o, err_memtype_o, resp_addr_o);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive(1'b1, 32'h0000_0500, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00);
    step();
    drive(1'b1, 32'h0000_0504, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    step();
    idle();
    n_cmp++;
    if ({outstanding_o, err_disallowed_o, violation_sticky_o} !== {4'd2, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL pre_reset: got cnt=%0d dis=%b sticky=%b want 2 1 1",
               outstanding_o, err_disallowed_o, violation_sticky_o);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({outstanding_o, resp_valid_o, resp_addr_o, resp_err_o, err_disallowed_o, err_memtype_o,
         err_overflow_o, err_underflow_o, err_timeout_o, violation_sticky_o} !== 44'h0) begin
      n_fail++;
      $display("FAIL async_reset: got cnt=%0d dis=%b sticky=%b want all 0",
               outstanding_o, err_disallowed_o, violation_sticky_o);
    end
    step();
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00);
    step();
    idle();
    n_cmp++;
    if ({err_underflow_o, resp_valid_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_discard: got und=%b rv=%b want 1 0", err_underflow_o, resp_valid_o);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_single_read();
    test_disallowed();
    test_overflow();
    test_underflow();
    test_timeout();
    test_memtype();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
